// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams and uart transmit handshake shared by the arbiter.
// Latency: none, wires only.
// Backpressure: req_ready per requester; uart_is_transmitting throttles uart_transmit.
//
// Ports (signals):
//   req_valid/req_data/req_last  requester -> arbiter, byte i at req_data[8i+7:8i]
//   req_ready                    arbiter -> requester, byte accepted this cycle
//   uart_transmit/uart_tx_byte   arbiter -> uart, start sending the byte
//   uart_is_transmitting         uart -> arbiter, uart busy flag
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 uart_transmit;
   logic [7:0]           uart_tx_byte;
   logic                 uart_is_transmitting;

   // Environment side: requesters plus the uart instance.
   modport master (
      output req_valid, req_data, req_last, uart_is_transmitting,
      input  req_ready, uart_transmit, uart_tx_byte
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_data, req_last, uart_is_transmitting,
      output req_ready, uart_transmit, uart_tx_byte
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter among NUM_REQ byte-stream requesters.
// Latency: byte accepted at cycle t raises uart_transmit at t+1; new grant 1 cycle after arbitration.
// Backpressure: only the granted requester sees req_ready, and only in S_LOAD, once per uart byte.
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   bus        uart_tx_arbiter_if.slave: requester streams and uart handshake
//   o_grant    one-hot owner of the uart, 0 when idle
//   o_busy     arbiter is serving a grant (state != S_ARB)
//   o_tx_err   sticky: uart never acknowledged a byte within TX_TIMEOUT cycles
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int MAX_PKT_LEN = 64,
   parameter int GAP_TIMEOUT = 1024,
   parameter int TX_TIMEOUT  = 4096
) (
   input  logic                clk,
   input  logic                rst,
   uart_tx_arbiter_if.slave    bus,
   output logic [NUM_REQ-1:0]  o_grant,
   output logic                o_busy,
   output logic                o_tx_err
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int GW = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
   localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);
   localparam logic [TW-1:0] TX_LAST  = TW'(TX_TIMEOUT - 1);
   localparam logic [7:0]    PKT_MAX  = 8'(MAX_PKT_LEN);

   typedef enum logic [2:0] {
      S_ARB,
      S_LOAD,
      S_WAIT,
      S_SEND,
      S_NEXT,
      S_REL
   } state_t;

   state_t              r_state;
   logic [NUM_REQ-1:0]  r_grant;
   logic [PW-1:0]       r_gidx;
   logic [PW-1:0]       r_rr_ptr;
   logic [7:0]          r_byte_cnt;
   logic                r_last_q;
   logic [7:0]          r_tx_byte;
   logic                r_transmit;
   logic                r_busy;
   logic                r_tx_err;
   logic [GW-1:0]       r_gap_cnt;
   logic [TW-1:0]       r_tx_cnt;

   logic                w_arb_found;
   logic [PW-1:0]       w_arb_idx;
   logic [NUM_REQ-1:0]  w_arb_onehot;
   logic [PW-1:0]       w_cand;
   logic [NUM_REQ-1:0]  w_req_ready;
   logic                w_xfer;
   logic [7:0]          w_sel_data;
   logic                w_sel_last;

   // Search upward from the requester after the last owner, wrapping at NUM_REQ,
   // so the most recent owner has lowest priority on the next round.
   always_comb begin
      w_arb_found  = 1'b0;
      w_arb_idx    = '0;
      w_arb_onehot = '0;
      w_cand       = r_rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = (w_cand == PW'(NUM_REQ - 1)) ? '0 : w_cand + PW'(1);
         if (!w_arb_found && bus.req_valid[w_cand]) begin
            w_arb_found = 1'b1;
            w_arb_idx   = w_cand;
         end
      end
      if (w_arb_found) begin
         w_arb_onehot[w_arb_idx] = 1'b1;
      end
   end

   // Byte and last flag of the current owner.
   always_comb begin
      w_sel_data = '0;
      w_sel_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_gidx == PW'(i)) begin
            w_sel_data = bus.req_data[8*i +: 8];
            w_sel_last = bus.req_last[i];
         end
      end
   end

   // Ready is a pass-through of the owner's valid, so a requester never waits
   // an extra cycle once the uart slot is free; everyone else stays stalled.
   assign w_req_ready = (r_state == S_LOAD) ? (r_grant & bus.req_valid) : '0;
   assign w_xfer      = |w_req_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_ARB;
         r_grant    <= '0;
         r_gidx     <= '0;
         r_rr_ptr   <= PW'(NUM_REQ - 1);
         r_byte_cnt <= '0;
         r_last_q   <= 1'b0;
         r_tx_byte  <= '0;
         r_transmit <= 1'b0;
         r_busy     <= 1'b0;
         r_tx_err   <= 1'b0;
         r_gap_cnt  <= '0;
         r_tx_cnt   <= '0;
      end else begin
         case (r_state)
            S_ARB: begin
               if (w_arb_found) begin
                  r_grant    <= w_arb_onehot;
                  r_gidx     <= w_arb_idx;
                  r_byte_cnt <= '0;
                  r_gap_cnt  <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_LOAD;
               end
            end

            S_LOAD: begin
               if (w_xfer) begin
                  r_tx_byte  <= w_sel_data;
                  r_last_q   <= w_sel_last;
                  r_byte_cnt <= r_byte_cnt + 8'd1;
                  r_tx_cnt   <= '0;
                  r_transmit <= 1'b1;
                  r_state    <= S_WAIT;
               end else if (r_gap_cnt == GAP_LAST) begin
                  // Owner stalled mid-packet: give the uart to someone else.
                  r_state <= S_REL;
               end else begin
                  r_gap_cnt <= r_gap_cnt + GW'(1);
               end
            end

            S_WAIT: begin
               if (bus.uart_is_transmitting) begin
                  r_transmit <= 1'b0;
                  r_state    <= S_SEND;
               end else if (r_tx_cnt == TX_LAST) begin
                  // Uart never picked the byte up; drop it and flag the fault.
                  r_transmit <= 1'b0;
                  r_tx_err   <= 1'b1;
                  r_state    <= S_REL;
               end else begin
                  r_tx_cnt <= r_tx_cnt + TW'(1);
               end
            end

            S_SEND: begin
               if (!bus.uart_is_transmitting) begin
                  r_state <= S_NEXT;
               end
            end

            S_NEXT: begin
               // Forced release at PKT_MAX keeps byte_cnt from wrapping; the
               // requester continues its stream on a later grant.
               if (r_last_q || (r_byte_cnt == PKT_MAX)) begin
                  r_state <= S_REL;
               end else begin
                  r_gap_cnt <= '0;
                  r_state   <= S_LOAD;
               end
            end

            S_REL: begin
               r_rr_ptr <= r_gidx;
               r_grant  <= '0;
               r_busy   <= 1'b0;
               r_state  <= S_ARB;
            end

            default: begin
               r_state <= S_ARB;
            end
         endcase
      end
   end

   assign bus.req_ready     = w_req_ready;
   assign bus.uart_transmit = r_transmit;
   assign bus.uart_tx_byte  = r_tx_byte;
   assign o_grant           = r_grant;
   assign o_busy            = r_busy;
   assign o_tx_err          = r_tx_err;

endmodule
